mem_store_buffer: RTL

Parametrised store path between the register-file read port and the data memory. Encodes each store into a byte-lane data word and a write-enable mask. Splits stores that cross a bus-word boundary into two beats, and queues the beats in a small FIFO with valid/ready handshakes on both sides. Sits between the execute stage (store request) and the data memory's write-data and byte-enable inputs.

---
 rtl/mem_store_buffer_pkg.sv | 17 +
 rtl/mem_store_buffer_sync_fifo.sv | 52 +++++
 rtl/mem_store_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_store_buffer_pkg.sv
// Shared definitions for the store path: size codes and FSM state type.
package mem_store_buffer_pkg;

  localparam logic [1:0] SZ_WORD    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_BYTE    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  // state | meaning
  // IDLE   | accepting requests; aligned stores push one beat
  // SECOND | split store in flight; latched beat 1 waits for FIFO space
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_e;

endpackage

// File: rtl/mem_store_buffer_sync_fifo.sv
// Synchronous FIFO with a registered head and an occupancy count.
// The head reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok;
  logic             pop_ok;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && valid_o;
  assign head_o  = valid_o ? mem_q[rd_q] : '0;

  // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_store_buffer.sv
// Store path: encodes stores into lane data plus byte enables, splits
// stores crossing a bus word into two beats, and queues beats for memory.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 4,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_data,
  input  logic [1:0]              req_size,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_data,
  output logic [DATA_W/8-1:0]     mem_be,
  output logic                    split_o,
  output logic                    err_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFS_W = $clog2(NB);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [NB-1:0]     be;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  state_e           state_q, state_d;
  beat_t            beat1_q, beat1_d;
  logic             split_q, split_d;
  logic             err_q, err_d;

  logic [OFS_W-1:0]    ofs;
  logic [NB-1:0]       size_be;
  logic [DATA_W-1:0]   size_dmask;
  logic [2*NB-1:0]     wide_be;
  logic [2*DATA_W-1:0] wide_data;
  logic [ADDR_W-1:0]   word_addr;
  beat_t               enc_beat0;
  beat_t               enc_beat1;
  logic                is_split;
  logic                is_illegal;

  logic                push;
  beat_t               push_beat;
  beat_t               head;
  logic                fifo_full;

  // Offset-ordered bytes map to lanes directly, or mirrored for big-endian.
  function automatic logic [DATA_W-1:0] lanes_data(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[8*i +: 8] = (BIG_ENDIAN != 0) ? d[8*(NB-1-i) +: 8] : d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [NB-1:0] lanes_be(input logic [NB-1:0] b);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++)
      r[i] = (BIG_ENDIAN != 0) ? b[NB-1-i] : b[i];
    return r;
  endfunction

  assign ofs        = req_addr[OFS_W-1:0];
  assign word_addr  = {req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
  assign is_illegal = (req_size == SZ_ILLEGAL);

  // Lane encoder: place the store across a double-width window indexed by
  // byte offset; the upper half is what spills into the next bus word.
  always_comb begin
    size_be = '0;
    case (req_size)
      SZ_WORD: size_be      = '1;
      SZ_HALF: size_be[1:0] = 2'b11;
      SZ_BYTE: size_be[0]   = 1'b1;
      default: size_be      = '0;
    endcase
    size_dmask = '0;
    for (int i = 0; i < NB; i++) size_dmask[8*i +: 8] = {8{size_be[i]}};
    wide_be   = {{NB{1'b0}}, size_be} << ofs;
    wide_data = {{DATA_W{1'b0}}, req_data & size_dmask} << {ofs, 3'b000};

    enc_beat0.addr = word_addr;
    enc_beat0.data = lanes_data(wide_data[DATA_W-1:0]);
    enc_beat0.be   = lanes_be(wide_be[NB-1:0]);
    enc_beat1.addr = word_addr + ADDR_W'(NB);
    enc_beat1.data = lanes_data(wide_data[2*DATA_W-1:DATA_W]);
    enc_beat1.be   = lanes_be(wide_be[2*NB-1:NB]);
    is_split       = |wide_be[2*NB-1:NB];
  end

  // Ready only looks at registered state so it never depends on mem_ready.
  assign req_ready = (state_q == ST_IDLE) && !fifo_full;

  // Next-state, beat-1 latch and push selection.
  always_comb begin
    state_d   = state_q;
    beat1_d   = beat1_q;
    split_d   = 1'b0;
    err_d     = 1'b0;
    push      = 1'b0;
    push_beat = enc_beat0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (is_illegal) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            if (is_split) begin
              beat1_d = enc_beat1;
              split_d = 1'b1;
              state_d = ST_SECOND;
            end
          end
        end
      end
      ST_SECOND: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_beat = beat1_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, latched second beat and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat1_q <= '0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat1_q <= beat1_d;
      split_q <= split_d;
      err_q   <= err_d;
    end
  end

  sync_fifo #(
    .W     (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_beat),
    .pop_i   (mem_ready),
    .head_o  (head),
    .valid_o (mem_valid),
    .full_o  (fifo_full),
    .count_o (count_o)
  );

  assign mem_addr = head.addr;
  assign mem_data = head.data;
  assign mem_be   = head.be;
  assign split_o  = split_q;
  assign err_o    = err_q;

endmodule
